screen_addr_gen: RTL
====================

// Module: screen_addr_gen
// PURPOSE
//  Neighbouring stage around screen_selector: converts VGA timing counters into the 20-bit
//  pixel address driven into screen_selector's addr_in. Consumes the returned rgb_pixel.
//  Delays all timing signals so sync/blank/counters leave aligned with that pixel.
//  Forces black in blanking. Emits a one-cycle frame_start pulse on the first visible pixel.
// PARAMETERS
//  SEL_LAT   2     cycles from addr_out to valid rgb_in (ROM read + selector output register)
//  H_ACTIVE  1024  visible pixels per line
//  V_ACTIVE  768   visible lines per frame
// PORTS
//  clk          in   1   system pixel clock; all logic on posedge
//  rst          in   1   synchronous, active-high reset
//  hcount_in    in   11  horizontal counter from VGA timing
//  vcount_in    in   11  vertical counter from VGA timing
//  hsync_in     in   1   horizontal sync from VGA timing
//  vsync_in     in   1   vertical sync from VGA timing
//  hblnk_in     in   1   horizontal blanking from VGA timing
//  vblnk_in     in   1   vertical blanking from VGA timing
//  addr_out     out  20  pixel address to screen_selector addr_in
//  rgb_in       in   12  pixel from screen_selector rgb_pixel
//  hcount_out   out  11  hcount_in delayed, aligned with rgb_out
//  vcount_out   out  11  vcount_in delayed, aligned with rgb_out
//  hsync_out    out  1   hsync_in delayed, aligned with rgb_out
//  vsync_out    out  1   vsync_in delayed, aligned with rgb_out
//  hblnk_out    out  1   hblnk_in delayed, aligned with rgb_out
//  vblnk_out    out  1   vblnk_in delayed, aligned with rgb_out
//  rgb_out      out  12  final pixel colour (4:4:4)
//  frame_start  out  1   1-cycle pulse aligned with pixel (0,0) on the outputs
// BEHAVIOUR
//  - Reset (sync, active-high): every output and every delay-line stage cleared to 0.
//    Outputs stay 0 for SEL_LAT+2 cycles after reset release (pipeline flush).
//  - Stage A, registered: addr_out = {vcount_in[9:0], hcount_in[9:0]} when
//    hcount_in<H_ACTIVE && vcount_in<V_ACTIVE; otherwise addr_out = 0. Latency 1.
//    No multiplier; the layout is a pure concatenation.
//  - The timing bundle (counters, syncs, blanks, visible flag) passes through a
//    SEL_LAT+1 stage shift register, so it lines up with rgb_in.
//  - Stage B, registered output: rgb_out = (hblnk_d|vblnk_d) ? 12'h000 : rgb_in.
//    The delayed timing bundle registers to the *_out ports in the same cycle.
//  - Total latency, in -> out: SEL_LAT+2 cycles (4 at default) for every output.
//  - frame_start = 1 for exactly one cycle, when the delayed counters are (0,0) and
//    not blanked. Never asserted while rst is high.
//  - Wrap-around: the last visible pixel (1023,767) gives addr 20'hBFFFF.
//    The next frame's (0,0) gives addr 0, with no glitch or hold.
//  - Counters beyond the visible area (blanking) give addr 0, and rgb_out is forced 0.
//  - Reset mid-frame: the pipeline is flushed to 0 on the next edge. After release the
//    outputs resume following the inputs, delayed SEL_LAT+2 cycles. No state survives.
// CONFIGURATION
//  SCREEN_HALFRES_EN defined:
//    - Images are stored at 512x384.
//    - addr_out = {2'b00, vcount_in[9:1], hcount_in[9:1]}, so each ROM pixel is shown 2x2.
//    - Last visible address is 18'h2FFFF.
//  SCREEN_HALFRES_EN undefined: full 1024x768 addressing as above.
// STRUCTURE
//  - game_pkg holds:
//    - H_ACTIVE and V_ACTIVE (localparams);
//    - SCREEN_ADDR_W = 20;
//    - the packed struct vga_tim_t {hcount, vcount, hsync, vsync, hblnk, vblnk}, used for
//      the delay line.
//  - One sub-module, delay_line: parameterised WIDTH and DEPTH, synchronous reset to 0.
//    It carries the packed vga_tim_t.
// TESTING
//  1. Reset: hold rst 3 cycles with active inputs -> all outputs 0. After release,
//     rgb_out/frame_start stay 0 for 4 cycles.
//  2. Address map: drive (h=5, v=2) -> addr_out=20'h00805 one cycle later.
//     Drive (1023,767) -> 20'hBFFFF. Drive (1100,10) -> 0.
//  3. Alignment: rgb_in model = addr delayed 2 cycles. Drive hcount=37 at cycle T ->
//     hcount_out=37 and the matching rgb_out at T+4.
//  4. Blanking: hblnk_in=1 with rgb_in=12'hFFF -> rgb_out=0 four cycles later.
//     Syncs propagate unchanged.
//  5. Frame wrap: run two full frames -> exactly one frame_start per frame, coincident
//     with hcount_out=0, vcount_out=0.
//  6. SCREEN_HALFRES_EN build: (h=5, v=3) -> addr_out=18'h00202.
//     (1023,767) -> 18'h2FFFF.

Source files
------------

// File: rtl/game_pkg.sv
// Shared screen constants, the VGA timing bundle and the pixel address map.
// SCREEN_HALFRES_EN selects the 512x384 map (each stored pixel shown 2x2).
package game_pkg;

  localparam logic [10:0] H_ACTIVE      = 11'd1024;
  localparam logic [10:0] V_ACTIVE      = 11'd768;
  localparam int          SCREEN_ADDR_W = 20;

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
  } vga_tim_t;

  // Row-major layout built by concatenation, so no multiplier is needed.
  function automatic logic [SCREEN_ADDR_W-1:0] pixel_addr(input logic [9:0] h,
                                                          input logic [9:0] v);
`ifdef SCREEN_HALFRES_EN
    return {2'b00, v[9:1], h[9:1]};
`else
    return {v, h};
`endif
  endfunction

endpackage

// File: rtl/screen_addr_gen_delay_line.sv
// Fixed-depth shift register with synchronous clear; carries the timing bundle.
module delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/screen_addr_gen.sv
// VGA counters -> screen_selector pixel address, with timing re-aligned to the returned pixel.
// Build option: SCREEN_HALFRES_EN (512x384 stored images, 2x2 pixel replication).
module screen_addr_gen
  import game_pkg::*;
#(
  parameter int SEL_LAT = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [10:0]              hcount_in,
  input  logic [10:0]              vcount_in,
  input  logic                     hsync_in,
  input  logic                     vsync_in,
  input  logic                     hblnk_in,
  input  logic                     vblnk_in,
  output logic [SCREEN_ADDR_W-1:0] addr_out,
  input  logic [11:0]              rgb_in,
  output logic [10:0]              hcount_out,
  output logic [10:0]              vcount_out,
  output logic                     hsync_out,
  output logic                     vsync_out,
  output logic                     hblnk_out,
  output logic                     vblnk_out,
  output logic [11:0]              rgb_out,
  output logic                     frame_start
);

  localparam int TIM_W = $bits(vga_tim_t);

  logic           visible;
  vga_tim_t       tim_in;
  vga_tim_t       tim_d;
  logic           visible_d;
  logic           blank_d;
  logic [TIM_W:0] dly_q;

  assign visible = (hcount_in < H_ACTIVE) && (vcount_in < V_ACTIVE);

  assign tim_in = '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in,
                    vsync: vsync_in, hblnk: hblnk_in, vblnk: vblnk_in};

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_out <= '0;
    end else if (visible) begin
      addr_out <= pixel_addr(hcount_in[9:0], vcount_in[9:0]);
    end else begin
      addr_out <= '0;
    end
  end

  // One extra stage covers the address register in front of the selector latency.
  delay_line #(
    .WIDTH (TIM_W + 1),
    .DEPTH (SEL_LAT + 1)
  ) u_tim_dly (
    .clk (clk),
    .rst (rst),
    .d   ({visible, tim_in}),
    .q   (dly_q)
  );

  assign {visible_d, tim_d} = dly_q;
  assign blank_d = tim_d.hblnk | tim_d.vblnk;

  // Gating on the delayed visible flag keeps rgb_out black while the pipeline refills.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_out  <= '0;
      vcount_out  <= '0;
      hsync_out   <= 1'b0;
      vsync_out   <= 1'b0;
      hblnk_out   <= 1'b0;
      vblnk_out   <= 1'b0;
      rgb_out     <= '0;
      frame_start <= 1'b0;
    end else begin
      hcount_out  <= tim_d.hcount;
      vcount_out  <= tim_d.vcount;
      hsync_out   <= tim_d.hsync;
      vsync_out   <= tim_d.vsync;
      hblnk_out   <= tim_d.hblnk;
      vblnk_out   <= tim_d.vblnk;
      rgb_out     <= (blank_d || !visible_d) ? 12'h000 : rgb_in;
      frame_start <= visible_d && !blank_d &&
                     (tim_d.hcount == 11'd0) && (tim_d.vcount == 11'd0);
    end
  end

endmodule
